fft_bfly_sched: RTL and testbench

FFT_BFLY_SCHED -- requirements
Module: fft_bfly_sched

---
 rtl/fft_bfly_sched.sv | 142 ++++++++++++++
 tb/tb_fft_bfly_sched.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bfly_sched.sv
// Radix-2 butterfly command scheduler: walks stage/group/butterfly counters,
// limits outstanding butterflies and drains between stages so no stage reads stale data.
module fft_bfly_sched #(
  parameter int FFT_SIZE = 1024,
  parameter int MAX_OUT  = 4,
  localparam int L  = $clog2(FFT_SIZE),
  localparam int SW = $clog2(L + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic          abort_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          cmd_valid_o,
  input  logic          cmd_ready_i,
  output logic [L-1:0]  cmd_u_addr_o,
  output logic [L-1:0]  cmd_v_addr_o,
  output logic [L-2:0]  cmd_tw_addr_o,
  output logic [SW-1:0] cmd_stage_o,
  output logic          cmd_last_o,
  input  logic          wb_i,
  output logic          wb_err_o
);

  localparam int IW = $clog2(MAX_OUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [L-1:0]  g_q, g_d, b_q, b_d;
  logic [IW-1:0] inf_q, inf_d;
  logic          err_q, err_d;

  logic          is_issue, cmd_valid, accept;
  logic          b_last, g_last, last_cmd;
  logic [L-1:0]  u_raw, v_raw;
  logic [L-2:0]  tw_raw;

  assign is_issue  = (state_q == ISSUE);
  assign cmd_valid = is_issue && (inf_q < IW'(MAX_OUT));
  assign accept    = cmd_valid && cmd_ready_i;

  // Address decode straight from the counters; counters only move on accept,
  // so a pending command never changes under the consumer.
  assign u_raw    = (g_q << (s_q + SW'(1))) + b_q;
  assign v_raw    = u_raw + (L'(1) << s_q);
  assign tw_raw   = (L-1)'(b_q << (SW'(L - 1) - s_q));
  assign b_last   = (b_q == ((L'(1) << s_q) - L'(1)));
  assign g_last   = (g_q == (L'((FFT_SIZE / 2) >> s_q) - L'(1)));
  assign last_cmd = (s_q == SW'(L - 1)) && (g_q == '0) && (b_q == L'(FFT_SIZE / 2 - 1));

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    g_d     = g_q;
    b_d     = b_q;
    inf_d   = inf_q;
    err_d   = err_q;

    // accept and write-back in the same cycle cancel out
    if (accept && !wb_i) begin
      inf_d = inf_q + IW'(1);
    end else if (!accept && wb_i) begin
      if (inf_q == '0) err_d = 1'b1;
      else             inf_d = inf_q - IW'(1);
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = ISSUE;
          s_d     = '0;
          g_d     = '0;
          b_d     = '0;
          inf_d   = '0;
          err_d   = 1'b0;
        end
      end
      ISSUE: begin
        if (accept) begin
          if (b_last) begin
            b_d = '0;
            if (g_last) begin
              g_d     = '0;
              s_d     = s_q + SW'(1);
              state_d = DRAIN;
            end else begin
              g_d = g_q + L'(1);
            end
          end else begin
            b_d = b_q + L'(1);
          end
        end
      end
      DRAIN: begin
        if (inf_q == '0) state_d = (s_q < SW'(L)) ? ISSUE : DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort_i) begin
      state_d = IDLE;
      s_d     = '0;
      g_d     = '0;
      b_d     = '0;
      inf_d   = '0;
      err_d   = err_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      s_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      inf_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      g_q     <= g_d;
      b_q     <= b_d;
      inf_q   <= inf_d;
      err_q   <= err_d;
    end
  end

  assign busy_o        = (state_q == ISSUE) || (state_q == DRAIN);
  assign done_o        = (state_q == DONE);
  assign cmd_valid_o   = cmd_valid;
  assign cmd_u_addr_o  = is_issue ? u_raw  : '0;
  assign cmd_v_addr_o  = is_issue ? v_raw  : '0;
  assign cmd_tw_addr_o = is_issue ? tw_raw : '0;
  assign cmd_stage_o   = is_issue ? s_q    : '0;
  assign cmd_last_o    = is_issue && last_cmd;
  assign wb_err_o      = err_q;

endmodule

// File: tb/tb_fft_bfly_sched.sv
// Scenario bench for fft_bfly_sched at FFT_SIZE=8, MAX_OUT=2; expected commands
// come from an index model queued at stimulus time and matched against accepted commands.
module tb_fft_bfly_sched;
  localparam int N  = 8;
  localparam int MO = 2;
  localparam int L  = 3;
  localparam int SW = 2;

  typedef struct packed {
    logic [L-1:0]  u;
    logic [L-1:0]  v;
    logic [L-2:0]  tw;
    logic [SW-1:0] s;
    logic          last;
  } cmd_t;

  logic          clk = 1'b0;
  logic          rst_ni, start_i, abort_i, cmd_ready_i;
  logic          wb_i = 1'b0;
  logic          busy_o, done_o, cmd_valid_o, cmd_last_o, wb_err_o;
  logic [L-1:0]  cmd_u_addr_o, cmd_v_addr_o;
  logic [L-2:0]  cmd_tw_addr_o;
  logic [SW-1:0] cmd_stage_o;

  cmd_t sb[$];
  cmd_t obs[$];
  int   checks = 0, failures = 0;
  int   n_done = 0, acc_cnt = 0, seen = 0;
  bit   auto_wb = 1'b0;
  logic man_wb = 1'b0;

  fft_bfly_sched #(.FFT_SIZE(N), .MAX_OUT(MO)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .busy_o(busy_o), .done_o(done_o), .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
    .cmd_u_addr_o(cmd_u_addr_o), .cmd_v_addr_o(cmd_v_addr_o), .cmd_tw_addr_o(cmd_tw_addr_o),
    .cmd_stage_o(cmd_stage_o), .cmd_last_o(cmd_last_o), .wb_i(wb_i), .wb_err_o(wb_err_o)
  );

  always #5 clk = ~clk;

  // monitor: record every command that will be accepted on the coming edge
  always @(negedge clk) begin
    if (rst_ni === 1'b1) begin
      if (cmd_valid_o && cmd_ready_i) begin
        obs.push_back({cmd_u_addr_o, cmd_v_addr_o, cmd_tw_addr_o, cmd_stage_o, cmd_last_o});
        acc_cnt++;
      end
      if (done_o) n_done++;
    end
  end

  // write-back source: either one pulse per accept one cycle later, or manual
  always @(posedge clk) begin
    #2;
    wb_i = auto_wb ? (acc_cnt != seen) : man_wb;
    seen = acc_cnt;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic void push_stage(input int s);
    cmd_t e;
    for (int k = 0; k < N / 2; k++) begin
      int b, g, u;
      b      = k % (1 << s);
      g      = k / (1 << s);
      u      = g * (2 << s) + b;
      e.u    = L'(u);
      e.v    = L'(u + (1 << s));
      e.tw   = (L-1)'(b * (1 << (L - 1 - s)));
      e.s    = SW'(s);
      e.last = (s == L - 1) && (k == N / 2 - 1);
      sb.push_back(e);
    end
  endfunction

  task automatic test_reset;
    rst_ni = 1'b0; start_i = 1'b0; abort_i = 1'b0; cmd_ready_i = 1'b0;
    cyc(2);
    checks++;
    if ({busy_o, done_o, cmd_valid_o, cmd_last_o, wb_err_o} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=00000", {busy_o, done_o, cmd_valid_o, cmd_last_o, wb_err_o});
    end
    checks++;
    if ({cmd_u_addr_o, cmd_v_addr_o, cmd_tw_addr_o, cmd_stage_o} !== '0) begin
      failures++;
      $display("FAIL reset_cmd got u=%0d v=%0d tw=%0d s=%0d exp all 0",
               cmd_u_addr_o, cmd_v_addr_o, cmd_tw_addr_o, cmd_stage_o);
    end
    rst_ni = 1'b1;
  endtask

  task automatic test_full_transform;
    int base, d0, t, n;
    cmd_t e;
    base = obs.size(); d0 = n_done;
    auto_wb = 1'b1; cmd_ready_i = 1'b1;
    for (int s = 0; s < L; s++) push_stage(s);
    n = sb.size();
    start_i = 1'b1; cyc(1); start_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1) begin failures++; $display("FAIL first_start busy got=%b exp=1", busy_o); end
    t = 0;
    while (done_o !== 1'b1 && t < 400) begin cyc(1); t++; end
    checks++;
    if (done_o !== 1'b1) begin
      failures++; $display("FAIL full_timeout done got=%b exp=1", done_o);
    end else begin
      start_i = 1'b1; cyc(1); start_i = 1'b0;
      checks++;
      if ({busy_o, done_o} !== 2'b00) begin
        failures++; $display("FAIL start_in_done busy,done got=%b exp=00", {busy_o, done_o});
      end
    end
    cyc(2);
    checks++;
    if (obs.size() - base !== n) begin
      failures++; $display("FAIL full_count got=%0d exp=%0d", obs.size() - base, n);
    end
    for (int i = 0; i < n; i++) begin
      e = sb.pop_front();
      checks++;
      if (base + i >= obs.size()) begin
        failures++; $display("FAIL full_cmd%0d missing exp u=%0d v=%0d", i, e.u, e.v);
      end else if (obs[base+i] !== e) begin
        failures++;
        $display("FAIL full_cmd%0d got u=%0d v=%0d tw=%0d s=%0d last=%b exp u=%0d v=%0d tw=%0d s=%0d last=%b",
                 i, obs[base+i].u, obs[base+i].v, obs[base+i].tw, obs[base+i].s, obs[base+i].last,
                 e.u, e.v, e.tw, e.s, e.last);
      end
    end
    checks++;
    if (n_done - d0 !== 1) begin failures++; $display("FAIL done_pulses got=%0d exp=1", n_done - d0); end
    auto_wb = 1'b0;
  endtask

  task automatic test_backpressure;
    int base;
    cmd_t e;
    base = obs.size(); man_wb = 1'b0; cmd_ready_i = 1'b1;
    push_stage(0);
    start_i = 1'b1; cyc(1); start_i = 1'b0;
    cyc(2);
    checks++;
    if (obs.size() - base !== 2 || cmd_valid_o !== 1'b0) begin
      failures++; $display("FAIL bp_two_accepts got n=%0d valid=%b exp n=2 valid=0", obs.size() - base, cmd_valid_o);
    end
    cyc(2);
    checks++;
    if (cmd_valid_o !== 1'b0 || cmd_u_addr_o !== 3'd4 || cmd_v_addr_o !== 3'd5 || obs.size() - base !== 2) begin
      failures++;
      $display("FAIL bp_held got valid=%b u=%0d v=%0d n=%0d exp valid=0 u=4 v=5 n=2",
               cmd_valid_o, cmd_u_addr_o, cmd_v_addr_o, obs.size() - base);
    end
    man_wb = 1'b1; cyc(1); man_wb = 1'b0;
    checks++;
    if (cmd_valid_o !== 1'b1 || cmd_u_addr_o !== 3'd4) begin
      failures++; $display("FAIL bp_resume got valid=%b u=%0d exp valid=1 u=4", cmd_valid_o, cmd_u_addr_o);
    end
    cyc(1);
    checks++;
    if (obs.size() - base !== 3 || cmd_valid_o !== 1'b0) begin
      failures++; $display("FAIL bp_third got n=%0d valid=%b exp n=3 valid=0", obs.size() - base, cmd_valid_o);
    end
    for (int i = 0; i < 3; i++) begin
      e = sb.pop_front();
      checks++;
      if (base + i >= obs.size() || obs[base+i] !== e) begin
        failures++; $display("FAIL bp_cmd%0d mismatch exp u=%0d v=%0d", i, e.u, e.v);
      end
    end
    sb.delete();
    abort_i = 1'b1; cyc(1); abort_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0) begin failures++; $display("FAIL bp_abort busy got=%b exp=0", busy_o); end
  endtask

  task automatic test_sim_acc_wb;
    int base;
    base = obs.size(); cmd_ready_i = 1'b0;
    start_i = 1'b1; cyc(1); start_i = 1'b0;
    cmd_ready_i = 1'b1; cyc(1);
    man_wb = 1'b1; cyc(1); man_wb = 1'b0;
    checks++;
    if (cmd_valid_o !== 1'b1 || cmd_u_addr_o !== 3'd4) begin
      failures++; $display("FAIL accwb_valid got valid=%b u=%0d exp valid=1 u=4", cmd_valid_o, cmd_u_addr_o);
    end
    cyc(1);
    checks++;
    if (cmd_valid_o !== 1'b0 || obs.size() - base !== 3) begin
      failures++; $display("FAIL accwb_full got valid=%b n=%0d exp valid=0 n=3", cmd_valid_o, obs.size() - base);
    end
    abort_i = 1'b1; cyc(1); abort_i = 1'b0;
  endtask

  task automatic test_stage_boundary;
    int base;
    cmd_t e;
    base = obs.size(); cmd_ready_i = 1'b1;
    push_stage(0);
    start_i = 1'b1; cyc(1); start_i = 1'b0;
    cyc(2);
    man_wb = 1'b1; cyc(2); man_wb = 1'b0;
    cyc(1);
    checks++;
    if (obs.size() - base !== 4 || busy_o !== 1'b1 || cmd_valid_o !== 1'b0) begin
      failures++; $display("FAIL sb_drain got n=%0d busy=%b valid=%b exp n=4 busy=1 valid=0",
                           obs.size() - base, busy_o, cmd_valid_o);
    end
    man_wb = 1'b1; cyc(2); man_wb = 1'b0;
    checks++;
    if (busy_o !== 1'b1 || cmd_valid_o !== 1'b0) begin
      failures++; $display("FAIL sb_exit_delay got busy=%b valid=%b exp busy=1 valid=0", busy_o, cmd_valid_o);
    end
    cyc(1);
    checks++;
    if ({cmd_valid_o, cmd_u_addr_o, cmd_v_addr_o, cmd_tw_addr_o, cmd_stage_o} !== {1'b1, 3'd0, 3'd2, 2'd0, 2'd1}) begin
      failures++; $display("FAIL sb_stage1_first got valid=%b u=%0d v=%0d tw=%0d s=%0d exp 1/0/2/0/1",
                           cmd_valid_o, cmd_u_addr_o, cmd_v_addr_o, cmd_tw_addr_o, cmd_stage_o);
    end
    for (int i = 0; i < 4; i++) begin
      e = sb.pop_front();
      checks++;
      if (base + i >= obs.size() || obs[base+i] !== e) begin
        failures++; $display("FAIL sb_cmd%0d mismatch exp u=%0d v=%0d", i, e.u, e.v);
      end
    end
    abort_i = 1'b1; cyc(1); abort_i = 1'b0;
  endtask

  task automatic test_abort;
    int base, d0, t;
    base = obs.size(); d0 = n_done;
    auto_wb = 1'b1; cmd_ready_i = 1'b1;
    start_i = 1'b1; cyc(1); start_i = 1'b0;
    t = 0;
    while (obs.size() - base < 8 && t < 100) begin cyc(1); t++; end
    checks++;
    if (obs.size() - base !== 8 || busy_o !== 1'b1 || cmd_valid_o !== 1'b0) begin
      failures++; $display("FAIL ab_in_drain got n=%0d busy=%b valid=%b exp n=8 busy=1 valid=0",
                           obs.size() - base, busy_o, cmd_valid_o);
    end
    abort_i = 1'b1; cyc(1); abort_i = 1'b0;
    auto_wb = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || cmd_valid_o !== 1'b0) begin
      failures++; $display("FAIL ab_idle got busy=%b valid=%b exp 0 0", busy_o, cmd_valid_o);
    end
    cyc(3);
    checks++;
    if (n_done !== d0 || wb_err_o !== 1'b0) begin
      failures++; $display("FAIL ab_no_done got done=%0d err=%b exp done=0 err=0", n_done - d0, wb_err_o);
    end
    cmd_ready_i = 1'b0;
    start_i = 1'b1; cyc(1); start_i = 1'b0;
    checks++;
    if ({cmd_valid_o, cmd_u_addr_o, cmd_v_addr_o, cmd_stage_o} !== {1'b1, 3'd0, 3'd1, 2'd0}) begin
      failures++; $display("FAIL ab_restart got valid=%b u=%0d v=%0d s=%0d exp 1/0/1/0",
                           cmd_valid_o, cmd_u_addr_o, cmd_v_addr_o, cmd_stage_o);
    end
    abort_i = 1'b1; cyc(1); abort_i = 1'b0;
  endtask

  task automatic test_wb_err;
    cmd_ready_i = 1'b0;
    man_wb = 1'b1; cyc(1); man_wb = 1'b0;
    checks++;
    if (wb_err_o !== 1'b1) begin failures++; $display("FAIL err_set got=%b exp=1", wb_err_o); end
    cyc(3);
    checks++;
    if (wb_err_o !== 1'b1) begin failures++; $display("FAIL err_hold got=%b exp=1", wb_err_o); end
    start_i = 1'b1; cyc(1); start_i = 1'b0;
    checks++;
    if (wb_err_o !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", wb_err_o); end
    cmd_ready_i = 1'b1; cyc(2);
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if ({busy_o, done_o, cmd_valid_o, cmd_last_o, wb_err_o} !== 5'b0) begin
      failures++; $display("FAIL async_rst_flags got=%b exp=00000", {busy_o, done_o, cmd_valid_o, cmd_last_o, wb_err_o});
    end
    checks++;
    if ({cmd_u_addr_o, cmd_v_addr_o, cmd_tw_addr_o, cmd_stage_o} !== '0) begin
      failures++; $display("FAIL async_rst_cmd got u=%0d v=%0d tw=%0d s=%0d exp all 0",
                           cmd_u_addr_o, cmd_v_addr_o, cmd_tw_addr_o, cmd_stage_o);
    end
    cmd_ready_i = 1'b0;
    rst_ni = 1'b1;
    cyc(2);
    checks++;
    if (busy_o !== 1'b0) begin failures++; $display("FAIL rst_discard busy got=%b exp=0", busy_o); end
  endtask

  initial begin
    test_reset();
    test_full_transform();
    test_backpressure();
    test_sim_acc_wb();
    test_stage_boundary();
    test_abort();
    test_wb_err();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
